battle_board: RTL and testbench

BATTLE_BOARD -- requirements
Module: battle_board

---
 rtl/battle_board.sv | 235 +++++++++++++++++++++++
 tb/tb_battle_board.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/battle_board.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : battle_board                                                  |
// | Purpose  : two-player ship placement / firing game with display readback |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module battle_board #(
    parameter int SIZE  = 8,
    parameter int SHIPS = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          place,
    input  logic [CW-1:0] cur_x,
    input  logic [CW-1:0] cur_y,
    input  logic [CW-1:0] rd_x_host,
    input  logic [CW-1:0] rd_y_host,
    input  logic [CW-1:0] rd_x_guest,
    input  logic [CW-1:0] rd_y_guest,
    output logic [1:0]    code_host,
    output logic [1:0]    code_guest,
    output logic [2:0]    phase,
    output logic          turn,
    output logic          ack,
    output logic          reject,
    output logic          shot_hit,
    output logic          winner
);

    localparam int c_ncell = SIZE * SIZE;
    localparam int c_iw    = (c_ncell > 1) ? $clog2(c_ncell) : 1;
    localparam int c_nw    = (SHIPS > 1) ? $clog2(SHIPS + 1) : 1;

    localparam logic [CW:0]     c_size = (CW+1)'(SIZE);
    localparam logic [c_nw-1:0] c_last = c_nw'(SHIPS - 1);

    localparam logic [1:0] c_empty = 2'b00;
    localparam logic [1:0] c_ship  = 2'b01;
    localparam logic [1:0] c_hit   = 2'b10;
    localparam logic [1:0] c_miss  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_PLACE_HOST  = 3'd1,
        ST_PLACE_GUEST = 3'd2,
        ST_BATTLE      = 3'd3,
        ST_OVER        = 3'd4
    } state_t;

    function automatic logic in_range(input logic [CW-1:0] x, input logic [CW-1:0] y);
        return ({1'b0, x} < c_size) && ({1'b0, y} < c_size);
    endfunction

    function automatic logic [c_iw-1:0] cell_idx(input logic [CW-1:0] x, input logic [CW-1:0] y);
        return c_iw'(int'(y) * SIZE + int'(x));
    endfunction

    state_t          r_state, w_state_n;
    logic            r_turn, w_turn_n;
    logic            r_winner, w_winner_n;
    logic            r_ack, w_ack_n;
    logic            r_reject, w_reject_n;
    logic            r_shot_hit, w_shot_hit_n;
    logic [c_nw-1:0] r_host_cnt, w_host_cnt_n;
    logic [c_nw-1:0] r_guest_cnt, w_guest_cnt_n;
    logic [c_nw-1:0] r_host_hits, w_host_hits_n;
    logic [c_nw-1:0] r_guest_hits, w_guest_hits_n;
    logic [1:0]      r_code_host, r_code_guest;
    logic [1:0]      r_host  [c_ncell];
    logic [1:0]      r_guest [c_ncell];

    logic            w_in;
    logic [c_iw-1:0] w_idx;
    logic [1:0]      w_cell;
    logic [c_nw-1:0] w_shooter_hits;
    logic            w_clear;
    logic            w_host_we;
    logic            w_guest_we;
    logic [1:0]      w_wdata;

    assign w_in  = in_range(cur_x, cur_y);
    assign w_idx = w_in ? cell_idx(cur_x, cur_y) : '0;

    // Target board: guest while the guest places or the host fires, host otherwise.
    assign w_cell = ((r_state == ST_PLACE_GUEST) || (r_state == ST_BATTLE && !r_turn))
                  ? r_guest[w_idx] : r_host[w_idx];
    assign w_shooter_hits = r_turn ? r_guest_hits : r_host_hits;

    always_comb begin
        w_state_n      = r_state;
        w_turn_n       = r_turn;
        w_winner_n     = r_winner;
        w_ack_n        = 1'b0;
        w_reject_n     = 1'b0;
        w_shot_hit_n   = 1'b0;
        w_host_cnt_n   = r_host_cnt;
        w_guest_cnt_n  = r_guest_cnt;
        w_host_hits_n  = r_host_hits;
        w_guest_hits_n = r_guest_hits;
        w_clear        = 1'b0;
        w_host_we      = 1'b0;
        w_guest_we     = 1'b0;
        w_wdata        = c_empty;

        case (r_state)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    w_clear        = 1'b1;
                    w_state_n      = ST_PLACE_HOST;
                    w_turn_n       = 1'b0;
                    w_winner_n     = 1'b0;
                    w_host_cnt_n   = '0;
                    w_guest_cnt_n  = '0;
                    w_host_hits_n  = '0;
                    w_guest_hits_n = '0;
                end
            end
            ST_PLACE_HOST: begin
                if (place) begin
                    if (!w_in || w_cell != c_empty) begin
                        w_reject_n = 1'b1;
                    end else begin
                        w_host_we    = 1'b1;
                        w_wdata      = c_ship;
                        w_ack_n      = 1'b1;
                        w_host_cnt_n = r_host_cnt + 1'b1;
                        if (r_host_cnt == c_last) w_state_n = ST_PLACE_GUEST;
                    end
                end
            end
            ST_PLACE_GUEST: begin
                if (place) begin
                    if (!w_in || w_cell != c_empty) begin
                        w_reject_n = 1'b1;
                    end else begin
                        w_guest_we    = 1'b1;
                        w_wdata       = c_ship;
                        w_ack_n       = 1'b1;
                        w_guest_cnt_n = r_guest_cnt + 1'b1;
                        if (r_guest_cnt == c_last) begin
                            w_state_n = ST_BATTLE;
                            w_turn_n  = 1'b0;
                        end
                    end
                end
            end
            ST_BATTLE: begin
                if (place) begin
                    if (!w_in || w_cell[1]) begin
                        w_reject_n = 1'b1;
                    end else begin
                        w_ack_n    = 1'b1;
                        w_host_we  = r_turn;
                        w_guest_we = !r_turn;
                        w_turn_n   = !r_turn;
                        if (w_cell == c_ship) begin
                            w_wdata      = c_hit;
                            w_shot_hit_n = 1'b1;
                            if (r_turn) w_guest_hits_n = r_guest_hits + 1'b1;
                            else        w_host_hits_n  = r_host_hits + 1'b1;
                            // Winning shot ends the game with the shooter still holding the turn.
                            if (w_shooter_hits == c_last) begin
                                w_state_n  = ST_OVER;
                                w_winner_n = r_turn;
                                w_turn_n   = r_turn;
                            end
                        end else begin
                            w_wdata = c_miss;
                        end
                    end
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_turn       <= 1'b0;
            r_winner     <= 1'b0;
            r_ack        <= 1'b0;
            r_reject     <= 1'b0;
            r_shot_hit   <= 1'b0;
            r_host_cnt   <= '0;
            r_guest_cnt  <= '0;
            r_host_hits  <= '0;
            r_guest_hits <= '0;
            r_code_host  <= c_empty;
            r_code_guest <= c_empty;
            for (int i = 0; i < c_ncell; i++) begin
                r_host[i]  <= c_empty;
                r_guest[i] <= c_empty;
            end
        end else begin
            r_state      <= w_state_n;
            r_turn       <= w_turn_n;
            r_winner     <= w_winner_n;
            r_ack        <= w_ack_n;
            r_reject     <= w_reject_n;
            r_shot_hit   <= w_shot_hit_n;
            r_host_cnt   <= w_host_cnt_n;
            r_guest_cnt  <= w_guest_cnt_n;
            r_host_hits  <= w_host_hits_n;
            r_guest_hits <= w_guest_hits_n;
            // Reads sample the pre-edge contents, so a same-edge write shows up one cycle later.
            r_code_host  <= in_range(rd_x_host, rd_y_host)
                          ? r_host[cell_idx(rd_x_host, rd_y_host)] : c_empty;
            r_code_guest <= in_range(rd_x_guest, rd_y_guest)
                          ? r_guest[cell_idx(rd_x_guest, rd_y_guest)] : c_empty;
            if (w_clear) begin
                for (int i = 0; i < c_ncell; i++) begin
                    r_host[i]  <= c_empty;
                    r_guest[i] <= c_empty;
                end
            end else begin
                if (w_host_we)  r_host[w_idx]  <= w_wdata;
                if (w_guest_we) r_guest[w_idx] <= w_wdata;
            end
        end
    end

    assign phase      = r_state;
    assign turn       = r_turn;
    assign winner     = r_winner;
    assign ack        = r_ack;
    assign reject     = r_reject;
    assign shot_hit   = r_shot_hit;
    assign code_host  = r_code_host;
    assign code_guest = r_code_guest;

endmodule
`default_nettype wire

// File: tb/tb_battle_board.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_battle_board                                               |
// | Purpose  : scoreboard bench for battle_board with directed game vectors  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_battle_board;

    localparam int SIZE  = 8;
    localparam int SHIPS = 4;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          place = 1'b0;
    logic [CW-1:0] cur_x = '0, cur_y = '0;
    logic [CW-1:0] rd_x_host = '0, rd_y_host = '0, rd_x_guest = '0, rd_y_guest = '0;
    logic [1:0]    code_host, code_guest;
    logic [2:0]    phase;
    logic          turn, ack, reject, shot_hit, winner;

    int errors = 0;
    int checks = 0;

    // Each entry: {expect_ack, expect_hit}; expect_ack=0 means a reject is expected.
    logic [1:0] exp_q[$];

    battle_board #(.SIZE(SIZE), .SHIPS(SHIPS), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .place(place),
        .cur_x(cur_x), .cur_y(cur_y),
        .rd_x_host(rd_x_host), .rd_y_host(rd_y_host),
        .rd_x_guest(rd_x_guest), .rd_y_guest(rd_y_guest),
        .code_host(code_host), .code_guest(code_guest),
        .phase(phase), .turn(turn), .ack(ack), .reject(reject),
        .shot_hit(shot_hit), .winner(winner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (ack || reject) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_response", 1, 0);
            end else begin
                logic [1:0] e;
                e = exp_q.pop_front();
                chk("resp_ack", int'(ack), int'(e[1]));
                chk("resp_reject", int'(reject), int'(!e[1]));
                if (e[1]) chk("resp_shot_hit", int'(shot_hit), int'(e[0]));
            end
        end
    end

    task automatic do_place(input int x, input int y, input bit exp_resp, input bit exp_ack,
                            input bit exp_hit);
        @(posedge clk); #1;
        cur_x = CW'(x);
        cur_y = CW'(y);
        place = 1'b1;
        if (exp_resp) exp_q.push_back({exp_ack, exp_hit});
        @(posedge clk); #1;
        place = 1'b0;
    endtask

    task automatic read_host(input int x, input int y, input int expv, input string name);
        rd_x_host = CW'(x);
        rd_y_host = CW'(y);
        @(posedge clk); #1;
        chk(name, int'(code_host), expv);
    endtask

    task automatic read_guest(input int x, input int y, input int expv, input string name);
        rd_x_guest = CW'(x);
        rd_y_guest = CW'(y);
        @(posedge clk); #1;
        chk(name, int'(code_guest), expv);
    endtask

    task automatic pulse_start(input bit with_place);
        @(posedge clk); #1;
        start = 1'b1;
        place = with_place;
        @(posedge clk); #1;
        start = 1'b0;
        place = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_phase", int'(phase), 0);
        chk("rst_turn", int'(turn), 0);
        chk("rst_winner", int'(winner), 0);
        chk("rst_ack", int'(ack), 0);
        chk("rst_code_host", int'(code_host), 0);
        chk("rst_code_guest", int'(code_guest), 0);
        rst = 1'b1;

        do_place(1, 1, 1'b0, 1'b0, 1'b0);
        chk("idle_place_phase", int'(phase), 0);
        pulse_start(1'b0);
        chk("start_phase", int'(phase), 1);

        do_place(0, 0, 1'b1, 1'b1, 1'b0);
        do_place(1, 1, 1'b1, 1'b1, 1'b0);
        do_place(1, 1, 1'b1, 1'b0, 1'b0);
        do_place(2, 2, 1'b1, 1'b1, 1'b0);
        chk("host_3_phase", int'(phase), 1);
        do_place(3, 3, 1'b1, 1'b1, 1'b0);
        chk("host_done_phase", int'(phase), 2);

        do_place(SIZE, 0, 1'b1, 1'b0, 1'b0);
        do_place(0, 0, 1'b1, 1'b1, 1'b0);
        do_place(4, 4, 1'b1, 1'b1, 1'b0);
        do_place(6, 6, 1'b1, 1'b1, 1'b0);
        do_place(7, 7, 1'b1, 1'b1, 1'b0);
        chk("guest_done_phase", int'(phase), 3);
        chk("battle_turn0", int'(turn), 0);

        pulse_start(1'b0);
        chk("start_ignored_battle", int'(phase), 3);

        do_place(0, 0, 1'b1, 1'b1, 1'b1);
        chk("turn_after_host_shot", int'(turn), 1);
        read_guest(0, 0, 2, "guest_00_hit");
        read_host(0, 0, 1, "host_00_ship");

        do_place(5, 5, 1'b1, 1'b1, 1'b0);
        chk("turn_after_guest_miss", int'(turn), 0);
        read_host(5, 5, 3, "host_55_miss");

        do_place(0, 0, 1'b1, 1'b0, 1'b0);
        chk("turn_after_refire", int'(turn), 0);

        do_place(4, 4, 1'b1, 1'b1, 1'b1);
        do_place(5, 6, 1'b1, 1'b1, 1'b0);

        rd_x_guest = CW'(6);
        rd_y_guest = CW'(6);
        do_place(6, 6, 1'b1, 1'b1, 1'b1);
        chk("same_edge_read_old", int'(code_guest), 1);
        @(posedge clk); #1;
        chk("same_edge_read_new", int'(code_guest), 2);

        do_place(0, 0, 1'b1, 1'b1, 1'b1);
        chk("turn_after_guest_hit", int'(turn), 0);
        do_place(7, 7, 1'b1, 1'b1, 1'b1);
        chk("over_phase", int'(phase), 4);
        chk("over_winner", int'(winner), 0);
        chk("over_turn", int'(turn), 0);

        do_place(1, 2, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("over_place_phase", int'(phase), 4);

        read_host(SIZE, 0, 0, "oob_read_host");
        read_host(0, 0, 2, "host_00_hit_held");
        read_guest(7, 7, 2, "guest_77_held");

        cur_x = CW'(5);
        cur_y = CW'(5);
        pulse_start(1'b1);
        chk("restart_phase", int'(phase), 1);
        read_host(5, 5, 0, "restart_cleared_host");
        read_guest(7, 7, 0, "restart_cleared_guest");

        for (int i = 0; i < SHIPS; i++) do_place(i, 0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < SHIPS; i++) do_place(i, 0, 1'b1, 1'b1, 1'b0);
        chk("second_battle_phase", int'(phase), 3);
        do_place(0, 0, 1'b1, 1'b1, 1'b1);

        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b1;
        place = 1'b1;
        @(posedge clk); #1;
        chk("midgame_rst_phase", int'(phase), 0);
        chk("midgame_rst_turn", int'(turn), 0);
        rst   = 1'b1;
        start = 1'b0;
        place = 1'b0;
        read_guest(0, 0, 0, "midgame_rst_guest_cell");
        read_host(1, 0, 0, "midgame_rst_host_cell");

        repeat (3) @(posedge clk);
        #1;
        chk("pending_responses", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
